// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter: multiply-by-10-and-add, one digit per clock, MSD first.
// Non-decimal nibbles are flagged through error and force the result to zero.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [WIDTH-1:0]      value,
  output logic                  ready,
  output logic                  error,
  output logic                  busy
);

  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DIGITS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q;
  logic [4*DIGITS-1:0] shift_q;
  logic [WIDTH-1:0]    acc_q;
  logic [CntW-1:0]     count_q;
  logic                bad_q;
  logic [WIDTH-1:0]    value_q;
  logic                ready_q;
  logic                error_q;
  logic                busy_q;

  logic                bad_in;
  logic [WIDTH-1:0]    acc_d;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  // acc*10 + top nibble, wrapping modulo 2^WIDTH
  always_comb begin
    acc_d = (acc_q << 3) + (acc_q << 1) + WIDTH'(shift_q[4*DIGITS-1 -: 4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      bad_q   <= 1'b0;
      value_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shift_q <= bcd;
            acc_q   <= '0;
            count_q <= '0;
            bad_q   <= bad_in;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_d;
          shift_q <= shift_q << 4;
          count_q <= count_q + 1'b1;
          if (count_q == LastCnt) begin
            value_q <= bad_q ? '0 : acc_d;
            error_q <= bad_q;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign value = value_q;
  assign ready = ready_q;
  assign error = error_q;
  assign busy  = busy_q;

endmodule
